// File: rtl/instr_feeder.sv
// Serial-to-parallel instruction loader: deserializes 9-bit words into an 8-deep FIFO and
// issues them to the CPU on START. Define INSTR_FEEDER_PARITY_EN for 10-bit frames with even parity and PERR.
module instr_feeder (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SER_IN,
  input  logic       SER_VALID,
  input  logic       START,
  input  logic       HOLD,
  output logic [8:0] INSTRUCTION,
  output logic       write_en,
  output logic       BUSY,
  output logic       DONE,
  output logic       FULL,
  output logic       EMPTY,
  output logic       OVERFLOW,
  output logic [3:0] COUNT
`ifdef INSTR_FEEDER_PARITY_EN
  ,
  output logic       PERR
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

`ifdef INSTR_FEEDER_PARITY_EN
  localparam int         SHIFT_W  = 9;
  localparam logic [3:0] LAST_BIT = 4'd9;
`else
  localparam int         SHIFT_W  = 8;
  localparam logic [3:0] LAST_BIT = 4'd8;
`endif

  logic [SHIFT_W-1:0] shift_reg;
  logic [3:0]         bit_cnt;
  logic               frame_end;
  logic               push_req;
  logic [8:0]         push_word;
  logic               push_ok;
  logic               pop;

  logic [8:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic [1:0] state;

  assign frame_end = SER_VALID && (bit_cnt == LAST_BIT);

  // The shift register holds all bits but the one arriving on the frame's final edge.
`ifdef INSTR_FEEDER_PARITY_EN
  logic parity_bad;
  assign parity_bad = ^{shift_reg, SER_IN};
  assign push_word  = shift_reg;
  assign push_req   = frame_end && !parity_bad;
`else
  assign push_word  = {shift_reg, SER_IN};
  assign push_req   = frame_end;
`endif

  assign pop     = (state == S_ISSUE) && (count != 4'd0) && !HOLD;
  assign push_ok = push_req && ((count != 4'd8) || pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_reg <= '0;
      bit_cnt   <= 4'd0;
    end else if (SER_VALID) begin
      shift_reg <= {shift_reg[SHIFT_W-2:0], SER_IN};
      bit_cnt   <= frame_end ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) OVERFLOW <= 1'b1;
    end
  end

`ifdef INSTR_FEEDER_PARITY_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                        PERR <= 1'b0;
    else if (frame_end && parity_bad) PERR <= 1'b1;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      INSTRUCTION <= 9'd0;
      write_en    <= 1'b0;
    end else begin
      write_en <= pop;
      if (pop) INSTRUCTION <= mem[rd_ptr];
      case (state)
        S_IDLE:  if (START) state <= S_ISSUE;
        S_ISSUE: if (!pop && (count == 4'd0)) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY  = (state == S_ISSUE);
  assign DONE  = (state == S_DONE);
  assign FULL  = (count == 4'd8);
  assign EMPTY = (count == 4'd0);
  assign COUNT = count;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: ordering, overflow, HOLD, empty run, reset and optional parity.
module tb_instr_feeder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SER_IN = 1'b0;
  logic       SER_VALID = 1'b0;
  logic       START = 1'b0;
  logic       HOLD = 1'b0;
  logic [8:0] INSTRUCTION;
  logic       write_en;
  logic       BUSY;
  logic       DONE;
  logic       FULL;
  logic       EMPTY;
  logic       OVERFLOW;
  logic [3:0] COUNT;
`ifdef INSTR_FEEDER_PARITY_EN
  logic       PERR;
`endif

  int total = 0;
  int bad = 0;

  logic [8:0] got[$];
  int done_cnt;
  int we_first;
  int we_last;

  instr_feeder dut (
    .CLK(CLK), .RESET(RESET), .SER_IN(SER_IN), .SER_VALID(SER_VALID),
    .START(START), .HOLD(HOLD), .INSTRUCTION(INSTRUCTION), .write_en(write_en),
    .BUSY(BUSY), .DONE(DONE), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW),
    .COUNT(COUNT)
`ifdef INSTR_FEEDER_PARITY_EN
    , .PERR(PERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 32'(INSTRUCTION), 32'h0);
    check({tag, "_we"},    32'(write_en), 32'h0);
    check({tag, "_busy"},  32'(BUSY), 32'h0);
    check({tag, "_done"},  32'(DONE), 32'h0);
    check({tag, "_full"},  32'(FULL), 32'h0);
    check({tag, "_empty"}, 32'(EMPTY), 32'h1);
    check({tag, "_count"}, 32'(COUNT), 32'h0);
    check({tag, "_ovf"},   32'(OVERFLOW), 32'h0);
`ifdef INSTR_FEEDER_PARITY_EN
    check({tag, "_perr"},  32'(PERR), 32'h0);
`endif
  endtask

  task automatic do_reset();
    SER_IN = 1'b0; SER_VALID = 1'b0; START = 1'b0; HOLD = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  // Sends n frame bits MSB first; rel drops HOLD just before the final bit's edge.
  task automatic send_frame(input logic [9:0] f, input int n, input bit rel);
    for (int i = n - 1; i >= 0; i--) begin
      SER_IN = f[i];
      SER_VALID = 1'b1;
      if (i == 0 && rel) HOLD = 1'b0;
      @(posedge CLK);
      #1;
    end
    SER_VALID = 1'b0;
    SER_IN = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] w, input bit rel);
`ifdef INSTR_FEEDER_PARITY_EN
    send_frame({w, ^w}, 10, rel);
`else
    send_frame({1'b0, w}, 9, rel);
`endif
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic collect(input int cycles);
    got.delete();
    done_cnt = 0;
    we_first = -1;
    we_last = -1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1;
      if (write_en) begin
        got.push_back(INSTRUCTION);
        if (we_first < 0) we_first = c;
        we_last = c;
      end
      if (DONE) done_cnt++;
    end
  endtask

  initial begin
    do_reset();
    check_reset_outputs("rst");

    // Two words, one run
    send_word(9'h1A5, 1'b0);
    send_word(9'h003, 1'b0);
    check("t1_count", 32'(COUNT), 32'd2);
    start_pulse();
    check("t1_busy", 32'(BUSY), 32'h1);
    collect(6);
    check("t1_n", 32'(got.size()), 32'd2);
    check("t1_w0", 32'(got[0]), 32'h1A5);
    check("t1_w1", 32'(got[1]), 32'h003);
    check("t1_consec", 32'(we_last - we_first), 32'd1);
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_count_end", 32'(COUNT), 32'd0);
    check("t1_busy_end", 32'(BUSY), 32'h0);

    // Overflow: ninth word dropped
    do_reset();
    for (int k = 1; k <= 9; k++) send_word(9'(k), 1'b0);
    check("t2_count", 32'(COUNT), 32'd8);
    check("t2_full", 32'(FULL), 32'h1);
    check("t2_empty", 32'(EMPTY), 32'h0);
    check("t2_ovf", 32'(OVERFLOW), 32'h1);
    start_pulse();
    collect(14);
    check("t2_n", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8; k++) check($sformatf("t2_w%0d", k), 32'(got[k]), 32'(k + 1));
    check("t2_done", 32'(done_cnt), 32'd1);
    check("t2_ovf_sticky", 32'(OVERFLOW), 32'h1);
    check("t2_empty_end", 32'(EMPTY), 32'h1);

    // HOLD stalls issue and freezes INSTRUCTION
    do_reset();
    send_word(9'h0A1, 1'b0);
    send_word(9'h0B2, 1'b0);
    send_word(9'h0C3, 1'b0);
    start_pulse();
    @(posedge CLK);
    #1;
    check("t3_first_we", 32'(write_en), 32'h1);
    check("t3_first_val", 32'(INSTRUCTION), 32'h0A1);
    HOLD = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      check($sformatf("t3_hold_we%0d", c), 32'(write_en), 32'h0);
      check($sformatf("t3_hold_val%0d", c), 32'(INSTRUCTION), 32'h0A1);
      check($sformatf("t3_hold_busy%0d", c), 32'(BUSY), 32'h1);
    end
    HOLD = 1'b0;
    collect(6);
    check("t3_n", 32'(got.size()), 32'd2);
    check("t3_w1", 32'(got[0]), 32'h0B2);
    check("t3_w2", 32'(got[1]), 32'h0C3);
    check("t3_done", 32'(done_cnt), 32'd1);

    // START with an empty FIFO
    do_reset();
    start_pulse();
    check("t4_busy", 32'(BUSY), 32'h1);
    check("t4_done0", 32'(DONE), 32'h0);
    check("t4_we0", 32'(write_en), 32'h0);
    @(posedge CLK);
    #1;
    check("t4_busy1", 32'(BUSY), 32'h0);
    check("t4_done1", 32'(DONE), 32'h1);
    check("t4_we1", 32'(write_en), 32'h0);
    @(posedge CLK);
    #1;
    check("t4_done2", 32'(DONE), 32'h0);
    check("t4_we2", 32'(write_en), 32'h0);

    // Simultaneous push and pop while FULL
    do_reset();
    for (int k = 0; k < 8; k++) send_word(9'(9'h010 + k), 1'b0);
    HOLD = 1'b1;
    start_pulse();
    check("t5_busy", 32'(BUSY), 32'h1);
    send_word(9'h018, 1'b1);
    check("t5_count", 32'(COUNT), 32'd8);
    check("t5_full", 32'(FULL), 32'h1);
    check("t5_ovf", 32'(OVERFLOW), 32'h0);
    check("t5_we", 32'(write_en), 32'h1);
    check("t5_val", 32'(INSTRUCTION), 32'h010);
    collect(14);
    check("t5_n", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8; k++) check($sformatf("t5_w%0d", k), 32'(got[k]), 32'(9'h011 + k));
    check("t5_done", 32'(done_cnt), 32'd1);

    // Reset mid-word with four words buffered
    do_reset();
    for (int k = 0; k < 4; k++) send_word(9'(9'h0A0 + k), 1'b0);
    check("t6_count", 32'(COUNT), 32'd4);
    SER_IN = 1'b1;
    SER_VALID = 1'b1;
    repeat (5) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    repeat (3) @(posedge CLK);
    #1;
    check("t6_count_held", 32'(COUNT), 32'd0);
    SER_VALID = 1'b0;
    SER_IN = 1'b0;
    RESET = 1'b0;
    send_word(9'h155, 1'b0);
    check("t6_count_new", 32'(COUNT), 32'd1);
    start_pulse();
    collect(5);
    check("t6_n", 32'(got.size()), 32'd1);
    check("t6_w0", 32'(got[0]), 32'h155);

`ifdef INSTR_FEEDER_PARITY_EN
    // Parity: good frame pushed, bad frame dropped
    do_reset();
    send_frame({9'h0FF, 1'b0}, 10, 1'b0);
    check("t7_count_good", 32'(COUNT), 32'd1);
    check("t7_perr_good", 32'(PERR), 32'h0);
    send_frame({9'h0FF, 1'b1}, 10, 1'b0);
    check("t7_count_bad", 32'(COUNT), 32'd1);
    check("t7_perr_bad", 32'(PERR), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
